uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter OVS, default 16: s_tick pulses per bit period, even, legal range 8..32.
REQ-003 SHALL have parameter PAR_MODE, default 0: parity mode, 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter NSTOP, default 1: stop bits checked, 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port s_tick, input, 1 bit: one-clk oversampling strobe, OVS pulses per bit.
REQ-009 SHALL have port dout, output, DBIT bits: received word, right-justified, LSB first on the line.
REQ-010 SHALL have port rx_valid, output, 1 bit: dout and the error flags hold a frame.
REQ-011 SHALL have port rx_ready, input, 1 bit: consumer accepts the frame.
REQ-012 SHALL have port parity_err, output, 1 bit: parity mismatch in the held frame.
REQ-013 SHALL have port frame_err, output, 1 bit: a stop bit sampled low in the held frame.
REQ-014 SHALL have port break_det, output, 1 bit: the held frame was all zeros, including parity and stop bits.
REQ-015 SHALL have port overrun, output, 1 bit: one-clk pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass rx through a 2-FF synchronizer (rx_s); all logic uses rx_s only.
REQ-017 SHALL shift rx_s into a 3-bit sample history on every s_tick; a bit value is the majority of that history.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, with s_reg counting ticks and n_reg counting bits.
REQ-019 SHALL handle IDLE: on rx_s == 0, go to START with s_reg = 0.
REQ-020 SHALL handle START: on the s_tick where s_reg == OVS/2-1, evaluate majority; if low, go to DATA with s_reg = n_reg = 0; if high, return to IDLE (false start, no output).
REQ-021 SHALL handle DATA: on the s_tick where s_reg == OVS-1, shift majority into the data register MSB (DBIT-wide, right shift) and clear s_reg.
REQ-022 SHALL leave DATA after bit DBIT-1: to PARITY if PAR_MODE != 0, else to STOP.
REQ-023 SHALL handle PARITY: at s_reg == OVS-1, capture the bit; error if XOR of data and parity bit is 1 (even) or 0 (odd).
REQ-024 SHALL handle STOP: at each s_reg == OVS-1, record a low majority as a frame error.
REQ-025 SHALL return to IDLE after stop-bit NSTOP is evaluated, at mid-stop, with no wait for the end of the bit.
REQ-026 SHALL, on that same clk, assert frame completion internally (done) for one cycle.
REQ-027 SHALL count only when s_tick = 1; between ticks, s_reg, n_reg and the state hold.
REQ-028 SHALL size s_reg at $clog2(OVS) bits and n_reg at $clog2(DBIT) bits, with no wrap beyond the terminal counts.
REQ-029 SHALL update the output register (dout, parity_err, frame_err, break_det) the clk after done, and set rx_valid then.
REQ-030 SHALL transfer a frame when rx_valid & rx_ready; rx_valid then clears next clk unless a new done loads simultaneously, in which case it stays 1 with the new data.
REQ-031 SHALL, on done while rx_valid = 1 and rx_ready = 0, keep the old frame, drop the new one, and pulse overrun for one clk.
REQ-032 SHALL hold dout and the flags stable while rx_valid = 1 and not accepted.
REQ-033 SHALL keep parity_err at 0 when PAR_MODE = 0.

Reset
REQ-034 SHALL, on reset == 0 at a clk edge, set state to IDLE, s_reg, n_reg, the data register, dout, all flags, rx_valid and overrun to 0, and the synchronizer and sample history to all-1s.
REQ-035 SHALL abort a frame in progress on reset mid-frame, with no output and no overrun.
REQ-036 SHALL, after reset release, require rx_s low to start a frame.

Structure
REQ-037 SHALL place state encoding (3-bit localparams) and PAR_MODE constants in shared package uart_pkg.
REQ-038 SHALL implement the synchronizer as sub-module uart_sync2, a 2-FF design with reset value 1.

Verification
REQ-039 SHALL cover, with defaults, frame 0x5A at OVS ticks/bit -> dout = 0x5A, rx_valid = 1, all flags 0, latency done+1 clk.
REQ-040 SHALL cover PAR_MODE = 2, DBIT = 7, byte 0x41 with parity bit 0 -> parity_err = 1; with parity bit 1 -> parity_err = 0.
REQ-041 SHALL cover a 5-tick low glitch on idle rx -> no rx_valid, FSM back in IDLE.
REQ-042 SHALL cover NSTOP = 2, second stop low -> frame_err = 1; rx held low a full frame -> break_det = 1, dout = 0.
REQ-043 SHALL cover two frames 0x11 and 0x22 with rx_ready = 0 -> dout = 0x11, one overrun pulse; rx_ready high on done -> dout = 0x22, rx_valid stays 1.
REQ-044 SHALL cover reset = 0 during data bit 3 -> outputs 0; the next clean frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, sampling helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Two-out-of-three vote used to turn the sample history into one bit value.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the input so downstream logic never sees a metastable value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterized UART receiver: oversampled majority sampling, optional parity,
// one or two stop bits, break detection and a valid/ready holding register.
module uart_rx_param #(
  parameter int DBIT     = 8,
  parameter int OVS      = 16,
  parameter int PAR_MODE = 0,
  parameter int NSTOP    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            overrun
);

  import uart_pkg::*;

  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID     = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_END     = SW'(OVS - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(NSTOP - 1);

  logic            rx_s;
  logic [2:0]      hist_reg;
  logic            maj;
  state_t          state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            perr_reg, perr_next;
  logic            ferr_reg, ferr_next;
  logic            zero_reg, zero_next;
  logic            done, done_next;

  uart_sync2 u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign maj = majority3(hist_reg);

  // Keep the last three oversampled values of the line for the majority vote.
  always_ff @(posedge clk) begin
    if (!reset)
      hist_reg <= 3'b111;
    else if (s_tick)
      hist_reg <= {hist_reg[1:0], rx_s};
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
      zero_reg  <= zero_next;
      done      <= done_next;
    end
  end

  // Next-state logic: counters only advance on s_tick, bits are taken at their centres.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    zero_next  = zero_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_MID) begin
            if (!maj) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
              perr_next  = 1'b0;
              ferr_next  = 1'b0;
              zero_next  = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_END) begin
            s_next = '0;
            b_next = {maj, b_reg[DBIT-1:1]};
            if (maj) zero_next = 1'b0;
            if (n_reg == N_LAST) begin
              n_next     = '0;
              state_next = (PAR_MODE != PAR_NONE) ? PARITY : STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_END) begin
            s_next     = '0;
            n_next     = '0;
            state_next = STOP;
            if (maj) zero_next = 1'b0;
            if (PAR_MODE == PAR_EVEN)
              perr_next = (^b_reg) ^ maj;
            else if (PAR_MODE == PAR_ODD)
              perr_next = ~((^b_reg) ^ maj);
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_END) begin
            s_next = '0;
            if (!maj) ferr_next = 1'b1;
            else      zero_next = 1'b0;
            if (n_reg == STOP_LAST) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register: load a finished frame unless an unaccepted one is pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          dout       <= b_reg;
          parity_err <= perr_reg;
          frame_err  <= ferr_reg;
          break_det  <= zero_reg;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param: three instances cover the default
// configuration, odd parity with 7 data bits, and two stop bits.
module tb_uart_rx_param;

  import uart_pkg::*;

  localparam int OVS      = 16;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_tick = 1'b0;
  int   div = 0;
  int   tick_cnt = 0;

  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
  logic [7:0] dout_a, dout_c;
  logic [6:0] dout_b;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic brk_a, brk_b, brk_c;
  logic ovr_a, ovr_b, ovr_c;
  int   ovr_cnt_a = 0;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_param u_def (
    .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick),
    .dout(dout_a), .rx_valid(valid_a), .rx_ready(rdy_a),
    .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a), .overrun(ovr_a)
  );

  uart_rx_param #(.DBIT(7), .PAR_MODE(2)) u_odd (
    .clk(clk), .reset(reset), .rx(rx_b), .s_tick(s_tick),
    .dout(dout_b), .rx_valid(valid_b), .rx_ready(rdy_b),
    .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b), .overrun(ovr_b)
  );

  uart_rx_param #(.NSTOP(2)) u_two (
    .clk(clk), .reset(reset), .rx(rx_c), .s_tick(s_tick),
    .dout(dout_c), .rx_valid(valid_c), .rx_ready(rdy_c),
    .parity_err(perr_c), .frame_err(ferr_c), .break_det(brk_c), .overrun(ovr_c)
  );

  always #5 clk = ~clk;

  // One-clk oversampling strobe every TICK_DIV clocks, changed away from the active edge.
  always @(negedge clk) begin
    if (div == TICK_DIV - 1) begin
      div    <= 0;
      s_tick <= 1'b1;
    end else begin
      div    <= div + 1;
      s_tick <= 1'b0;
    end
  end

  // Count strobes seen by the DUT so stimulus can be timed in ticks.
  always @(posedge clk) begin
    if (s_tick) tick_cnt <= tick_cnt + 1;
  end

  // Count overrun pulses of the default instance.
  always @(negedge clk) begin
    if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
  end

  // Hang guard.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = tick_cnt;
    while (tick_cnt - t0 < n) @(negedge clk);
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  function automatic logic get_valid(input int w);
    case (w)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  // Drives a frame and returns two ticks before the centre of the last stop bit.
  task automatic applyStimulus(input int w, input logic [8:0] data, input int nbits,
                               input logic has_par, input logic par_bit,
                               input int nstop, input logic [1:0] stop_lvl);
    wait_ticks(1);
    set_rx(w, 1'b0);
    wait_ticks(OVS);
    for (int i = 0; i < nbits; i++) begin
      set_rx(w, data[i]);
      wait_ticks(OVS);
    end
    if (has_par) begin
      set_rx(w, par_bit);
      wait_ticks(OVS);
    end
    for (int j = 0; j < nstop; j++) begin
      set_rx(w, stop_lvl[j]);
      if (j == nstop - 1) wait_ticks(OVS/2 - 2);
      else                wait_ticks(OVS);
    end
  endtask

  task automatic go_idle(input int w, input int n);
    set_rx(w, 1'b1);
    wait_ticks(n);
  endtask

  task automatic wait_valid(input int w, output logic seen, output logic done_before);
    logic last_done;
    seen        = 1'b0;
    done_before = 1'b0;
    last_done   = u_def.done;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (get_valid(w)) begin
        seen        = 1'b1;
        done_before = last_done;
      end
      last_done = u_def.done;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_ticks(4);
  endtask

  initial begin
    logic seen, dbef, found;
    int   base;

    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("reset_valid", valid_a, 1'b0);
    checkOutput("reset_dout", dout_a, 8'h00);
    checkOutput("reset_flags", {perr_a, ferr_a, brk_a, ovr_a}, 4'b0000);
    checkOutput("reset_state", u_def.state_reg, ST_IDLE);
    reset = 1'b1;
    wait_ticks(4);

    // Default frame 0x5A
    applyStimulus(0, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b11);
    checkOutput("a5_pre_done_valid", valid_a, 1'b0);
    wait_valid(0, seen, dbef);
    checkOutput("a5_valid_seen", seen, 1'b1);
    checkOutput("a5_latency_done_plus1", dbef, 1'b1);
    checkOutput("a5_dout", dout_a, 8'h5A);
    checkOutput("a5_flags", {perr_a, ferr_a, brk_a}, 3'b000);
    go_idle(0, 8);
    checkOutput("a5_hold_dout", dout_a, 8'h5A);
    checkOutput("a5_hold_valid", valid_a, 1'b1);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    checkOutput("a5_accept_clears", valid_a, 1'b0);

    // Short low glitch on idle line
    wait_ticks(1);
    rx_a = 1'b0;
    wait_ticks(5);
    rx_a = 1'b1;
    wait_ticks(24);
    checkOutput("glitch_no_valid", valid_a, 1'b0);
    checkOutput("glitch_state_idle", u_def.state_reg, ST_IDLE);

    // Odd parity, 7 data bits, 0x41: parity bit 0 is wrong, 1 is right
    applyStimulus(1, 9'h041, 7, 1'b1, 1'b0, 1, 2'b11);
    wait_valid(1, seen, dbef);
    checkOutput("odd_p0_valid", seen, 1'b1);
    checkOutput("odd_p0_dout", dout_b, 7'h41);
    checkOutput("odd_p0_parity_err", perr_b, 1'b1);
    checkOutput("odd_p0_frame_err", ferr_b, 1'b0);
    go_idle(1, 8);
    rdy_b = 1'b1;
    @(negedge clk);
    rdy_b = 1'b0;
    applyStimulus(1, 9'h041, 7, 1'b1, 1'b1, 1, 2'b11);
    wait_valid(1, seen, dbef);
    checkOutput("odd_p1_valid", seen, 1'b1);
    checkOutput("odd_p1_dout", dout_b, 7'h41);
    checkOutput("odd_p1_parity_err", perr_b, 1'b0);
    go_idle(1, 8);

    // Two stop bits, second one low
    applyStimulus(2, 9'h0A5, 8, 1'b0, 1'b0, 2, 2'b01);
    wait_valid(2, seen, dbef);
    checkOutput("stop2_valid", seen, 1'b1);
    checkOutput("stop2_dout", dout_c, 8'hA5);
    checkOutput("stop2_frame_err", ferr_c, 1'b1);
    checkOutput("stop2_break", brk_c, 1'b0);
    pulse_reset();
    checkOutput("stop2_reset_valid", valid_c, 1'b0);

    // Line held low for a whole frame
    applyStimulus(2, 9'h000, 8, 1'b0, 1'b0, 2, 2'b00);
    wait_valid(2, seen, dbef);
    checkOutput("break_valid", seen, 1'b1);
    checkOutput("break_det", brk_c, 1'b1);
    checkOutput("break_dout", dout_c, 8'h00);
    checkOutput("break_frame_err", ferr_c, 1'b1);
    checkOutput("break_parity_err", perr_c, 1'b0);
    pulse_reset();

    // Overrun: second frame dropped while first is unaccepted
    base = ovr_cnt_a;
    applyStimulus(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b11);
    wait_valid(0, seen, dbef);
    checkOutput("ovr_first_dout", dout_a, 8'h11);
    go_idle(0, 8);
    applyStimulus(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11);
    go_idle(0, 8);
    checkOutput("ovr_keep_dout", dout_a, 8'h11);
    checkOutput("ovr_keep_valid", valid_a, 1'b1);
    checkOutput("ovr_one_pulse", ovr_cnt_a - base, 1);
    // Accept on the same clk a new frame completes
    applyStimulus(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11);
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (u_def.done) found = 1'b1;
    end
    checkOutput("sim_done_seen", found, 1'b1);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    checkOutput("sim_valid_stays", valid_a, 1'b1);
    checkOutput("sim_new_dout", dout_a, 8'h22);
    checkOutput("sim_no_extra_ovr", ovr_cnt_a - base, 1);
    go_idle(0, 8);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;

    // Reset in the middle of data bit 3, then a clean 0xC3
    wait_ticks(1);
    rx_a = 1'b0;
    wait_ticks(OVS);
    rx_a = 1'b1; wait_ticks(OVS);
    rx_a = 1'b1; wait_ticks(OVS);
    rx_a = 1'b0; wait_ticks(OVS);
    rx_a = 1'b0; wait_ticks(OVS/2);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    rx_a = 1'b1;
    checkOutput("midrst_valid", valid_a, 1'b0);
    checkOutput("midrst_dout", dout_a, 8'h00);
    checkOutput("midrst_state", u_def.state_reg, ST_IDLE);
    reset = 1'b1;
    base = ovr_cnt_a;
    wait_ticks(3 * OVS);
    checkOutput("midrst_no_output", valid_a, 1'b0);
    applyStimulus(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 2'b11);
    wait_valid(0, seen, dbef);
    checkOutput("c3_valid", seen, 1'b1);
    checkOutput("c3_dout", dout_a, 8'hC3);
    checkOutput("c3_flags", {perr_a, ferr_a, brk_a}, 3'b000);
    checkOutput("c3_no_overrun", ovr_cnt_a - base, 0);
    go_idle(0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
